ime_best_mv_x16: RTL and testbench
==================================

Name: ime_best_mv_x16

Overview:
- Sits directly downstream of the registered x16 cost adder in the IME pipeline.
- Consumes one set of per-candidate costs per cycle: 8x16 (x2), 16x8 (x2), 16x16 (x1).
- Keeps the running minimum cost and its motion vector independently for each of the 5 partitions over one MB search.
- Presents the winners to the partition-decision stage with a one-cycle done pulse.

Parameters:
- COST_W, 16, width of one partition cost.
- MV_W, 8, width of one signed MV component.
- CNT_W, 10, width of the candidate counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  pulse: begin a new MB search and clear the trackers.
- cost_v_i  in  1  costs and mv_i valid this cycle (aligned with the registered cost outputs).
- last_i  in  1  qualifies cost_v_i: this candidate is the final one of the search.
- mv_i  in  2*MV_W  candidate MV {mvx, mvy}, two's complement, mvx in the upper half.
- cost8x16_i  in  2*COST_W  slot 0 = left partition.
- cost16x8_i  in  2*COST_W  slot 0 = top partition.
- cost16x16_i  in  COST_W.
- best_cost8x16_o  out  2*COST_W.
- best_cost16x8_o  out  2*COST_W.
- best_cost16x16_o  out  COST_W.
- best_mv8x16_o  out  4*MV_W  slot i = {mvx, mvy} at [(i+1)*2*MV_W-1 : i*2*MV_W].
- best_mv16x8_o  out  4*MV_W  same packing.
- best_mv16x16_o  out  2*MV_W.
- busy_o  out  1  high in SEARCH.
- done_o  out  1  one-cycle pulse; results final.
- cand_cnt_o  out  CNT_W  candidates accepted in the current/last search.

Behaviour:
- Reset (rstn low, async): FSM=IDLE, all best costs = all-ones, all best MVs = 0, busy_o=0, done_o=0, cand_cnt_o=0.
- Cost slot packing: slot i at [(i+1)*COST_W-1 : i*COST_W].
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - cost_v_i is ignored.
  - start_i -> SEARCH next cycle; on that edge costs go to all-ones, MVs to 0, cand_cnt_o to 0.
- SEARCH (busy_o=1), on each cost_v_i:
  - Each of the 5 trackers compares independently, unsigned.
  - If the input cost is strictly less than the stored best, store the cost and mv_i on the next edge; otherwise hold.
  - On ties the earlier candidate is kept.
  - cand_cnt_o increments and saturates at 2^CNT_W-1.
- Last candidate: cost_v_i && last_i in SEARCH -> that candidate is compared normally, then the FSM goes to DONE.
- last_i without cost_v_i has no effect.
- DONE: done_o=1 for exactly one cycle, then IDLE.
  - Latency: done_o is high 1 cycle after the clock edge that accepted the last candidate.
  - The best_* outputs are final while done_o=1.
- Outputs are registers; they hold after done until the next start_i.
- start_i in SEARCH or DONE: aborts the search and re-initialises as from IDLE. Any cost_v_i in the same cycle is discarded. No done_o is issued for the aborted search; a start_i in DONE still lets that cycle's done_o pulse complete.
- No candidate before last (single-candidate search): the first and only candidate always wins, because any cost is less than all-ones unless the cost is all-ones.
- An input cost of all-ones never updates a tracker; its MV stays 0.
- Reset mid-search returns to the reset state immediately; no done_o.

Optional Feature:
- Macro: IME_TIE_SMALL_MV_EN.
- Defined: on an equal cost, the tracker replaces the stored entry if |mvx|+|mvy| of the candidate is strictly less than that of the stored MV. Magnitudes are computed at MV_W+1 bits, so -2^(MV_W-1) is handled without overflow. The candidate-magnitude computation is shared across the 5 trackers.
- Not defined: equal cost never replaces the stored entry (earliest wins).

Test Plan:
- Reset, start, then 3 candidates with 16x16 costs 500, 300, 300 and MVs (1,1), (2,-3), (0,1), last on the 3rd -> best_cost16x16_o=300, best_mv16x16_o=(2,-3) without the macro, (0,1) with it. done_o pulses 1 cycle after the 3rd accept; cand_cnt_o=3.
- Per-partition independence: 2 candidates MV A=(4,0) and B=(-4,0).
  - cost8x16 {A: 10/90, B: 20/80} -> left=10 with MV A, right=80 with MV B.
  - Analogous independent outcomes for 16x8.
- Abort: start, 2 candidates, start again while a cost_v_i of cost 5 is present -> that candidate is discarded. Costs read all-ones and cand_cnt_o=0 after the restart; no done_o for the first search.
- cost_v_i with cost 1 while IDLE -> no change to any output. Single candidate with cost 0 and last_i -> best cost 0, done_o asserted.
- Gaps in cost_v_i (valid every 3rd cycle, 5 candidates) -> same result as back-to-back; busy_o stays high throughout.
- Assert rstn low mid-search -> all outputs return to reset values asynchronously, and no done_o follows.

Source files
------------

// File: rtl/ime_best_mv_x16.sv
// ----------------------------------------------------------------------------
// ime_best_mv_x16
//
// Running-minimum tracker for the five x16 partitions (8x16 left/right,
// 16x8 top/bottom, 16x16) over one macroblock integer-ME search. Each cycle
// in which cost_v_i is high, every partition compares its candidate cost
// against its stored best and keeps the smaller one together with mv_i.
// When the candidate flagged by last_i has been absorbed, done_o pulses for
// one cycle with the final winners on the best_* outputs.
//
// Optional build macro: IME_TIE_SMALL_MV_EN
//   defined   : on equal cost, the candidate replaces the stored entry when
//               its |mvx|+|mvy| is strictly smaller.
//   undefined : on equal cost the earliest candidate is kept.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start_i            begin a new search (also aborts a running one)
//   cost_v_i, last_i   candidate valid / final candidate of the search
//   mv_i               candidate MV {mvx, mvy}, two's complement
//   cost8x16_i         {right, left} costs
//   cost16x8_i         {bottom, top} costs
//   cost16x16_i        16x16 cost
//   best_cost*_o       running best cost per partition (same packing)
//   best_mv*_o         MV of the best cost per partition (same packing)
//   busy_o             search in progress
//   done_o             one-cycle pulse, results final
//   cand_cnt_o         accepted candidates, saturating
// ----------------------------------------------------------------------------
module ime_best_mv_x16 #(
    parameter int COST_W = 16,
    parameter int MV_W   = 8,
    parameter int CNT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  cost_v_i,
    input  logic                  last_i,
    input  logic [2*MV_W-1:0]     mv_i,
    input  logic [2*COST_W-1:0]   cost8x16_i,
    input  logic [2*COST_W-1:0]   cost16x8_i,
    input  logic [COST_W-1:0]     cost16x16_i,
    output logic [2*COST_W-1:0]   best_cost8x16_o,
    output logic [2*COST_W-1:0]   best_cost16x8_o,
    output logic [COST_W-1:0]     best_cost16x16_o,
    output logic [4*MV_W-1:0]     best_mv8x16_o,
    output logic [4*MV_W-1:0]     best_mv16x8_o,
    output logic [2*MV_W-1:0]     best_mv16x16_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      cand_cnt_o
);

    localparam int NPART = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cand_cnt_q, cand_cnt_d;
    logic               accept;

    // Tracker index map: 0/1 = 8x16 left/right, 2/3 = 16x8 top/bottom, 4 = 16x16
    logic [COST_W-1:0]  cost_in   [NPART];
    logic [COST_W-1:0]  best_cost [NPART];
    logic [2*MV_W-1:0]  best_mv   [NPART];

    assign cost_in[0] = cost8x16_i[COST_W-1:0];
    assign cost_in[1] = cost8x16_i[2*COST_W-1:COST_W];
    assign cost_in[2] = cost16x8_i[COST_W-1:0];
    assign cost_in[3] = cost16x8_i[2*COST_W-1:COST_W];
    assign cost_in[4] = cost16x16_i;

    // A start in the same cycle wins over any candidate, which is dropped.
    assign accept = (state_q == S_SEARCH) && cost_v_i && !start_i;

`ifdef IME_TIE_SMALL_MV_EN
    // |mvx|+|mvy|; each abs is taken at MV_W+1 bits so the most negative
    // component (-2^(MV_W-1)) becomes a positive value without wrapping.
    function automatic logic [MV_W+1:0] mv_mag(input logic [2*MV_W-1:0] mv);
        logic [MV_W:0] ax;
        logic [MV_W:0] ay;
        ax = {mv[2*MV_W-1], mv[2*MV_W-1:MV_W]};
        ay = {mv[MV_W-1], mv[MV_W-1:0]};
        if (ax[MV_W]) ax = -ax;
        if (ay[MV_W]) ay = -ay;
        return {1'b0, ax} + {1'b0, ay};
    endfunction

    // Candidate magnitude is computed once and shared by all trackers.
    logic [MV_W+1:0] cand_mag;
    assign cand_mag = mv_mag(mv_i);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NPART; gi++) begin : g_trk
            logic [COST_W-1:0] cost_q, cost_d;
            logic [2*MV_W-1:0] mv_q, mv_d;
            logic              wins;

`ifdef IME_TIE_SMALL_MV_EN
            assign wins = (cost_in[gi] < cost_q) ||
                          ((cost_in[gi] == cost_q) && (cand_mag < mv_mag(mv_q)));
`else
            // Strict compare: ties keep the earlier candidate.
            assign wins = (cost_in[gi] < cost_q);
`endif

            always_comb begin
                cost_d = cost_q;
                mv_d   = mv_q;
                if (start_i) begin
                    cost_d = '1;
                    mv_d   = '0;
                end else if (accept && wins) begin
                    cost_d = cost_in[gi];
                    mv_d   = mv_i;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cost_q <= '1;
                    mv_q   <= '0;
                end else begin
                    cost_q <= cost_d;
                    mv_q   <= mv_d;
                end
            end

            assign best_cost[gi] = cost_q;
            assign best_mv[gi]   = mv_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cand_cnt_d = cand_cnt_q;
        if (start_i) begin
            state_d    = S_SEARCH;
            cand_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_SEARCH: begin
                    if (accept) begin
                        if (cand_cnt_q != {CNT_W{1'b1}}) begin
                            cand_cnt_d = cand_cnt_q + 1'b1;
                        end
                        if (last_i) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cand_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cand_cnt_q <= cand_cnt_d;
        end
    end

    assign busy_o     = (state_q == S_SEARCH);
    assign done_o     = (state_q == S_DONE);
    assign cand_cnt_o = cand_cnt_q;

    assign best_cost8x16_o  = {best_cost[1], best_cost[0]};
    assign best_cost16x8_o  = {best_cost[3], best_cost[2]};
    assign best_cost16x16_o = best_cost[4];
    assign best_mv8x16_o    = {best_mv[1], best_mv[0]};
    assign best_mv16x8_o    = {best_mv[3], best_mv[2]};
    assign best_mv16x16_o   = best_mv[4];

endmodule

// File: tb/tb_ime_best_mv_x16.sv
module tb_ime_best_mv_x16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic        cost_v_i = 1'b0;
    logic        last_i = 1'b0;
    logic [15:0] mv_i = '0;
    logic [31:0] cost8x16_i = '0;
    logic [31:0] cost16x8_i = '0;
    logic [15:0] cost16x16_i = '0;
    logic [31:0] best_cost8x16_o;
    logic [31:0] best_cost16x8_o;
    logic [15:0] best_cost16x16_o;
    logic [31:0] best_mv8x16_o;
    logic [31:0] best_mv16x8_o;
    logic [15:0] best_mv16x16_o;
    logic        busy_o;
    logic        done_o;
    logic [9:0]  cand_cnt_o;

    ime_best_mv_x16 dut (
        .clk              (clk),
        .rstn             (rstn),
        .start_i          (start_i),
        .cost_v_i         (cost_v_i),
        .last_i           (last_i),
        .mv_i             (mv_i),
        .cost8x16_i       (cost8x16_i),
        .cost16x8_i       (cost16x8_i),
        .cost16x16_i      (cost16x16_i),
        .best_cost8x16_o  (best_cost8x16_o),
        .best_cost16x8_o  (best_cost16x8_o),
        .best_cost16x16_o (best_cost16x16_o),
        .best_mv8x16_o    (best_mv8x16_o),
        .best_mv16x8_o    (best_mv16x8_o),
        .best_mv16x16_o   (best_mv16x16_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .cand_cnt_o       (cand_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [79:0] cost;
        logic [79:0] mv;
        logic [9:0]  cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model of the search, order: 8x16 L,R, 16x8 T,B, 16x16
    logic [15:0] m_cost [5];
    logic [15:0] m_mv   [5];
    logic [9:0]  m_cnt;
    bit          m_search;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [79:0] pk(input logic [15:0] c0, input logic [15:0] c1,
                                       input logic [15:0] c2, input logic [15:0] c3,
                                       input logic [15:0] c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    function automatic int mag(input logic [15:0] mv);
        int x;
        int y;
        x = int'($signed(mv[15:8]));
        y = int'($signed(mv[7:0]));
        if (x < 0) x = -x;
        if (y < 0) y = -y;
        return x + y;
    endfunction

    task automatic model_reset(input bit searching);
        for (int i = 0; i < 5; i++) begin
            m_cost[i] = 16'hFFFF;
            m_mv[i]   = 16'h0000;
        end
        m_cnt    = '0;
        m_search = searching;
    endtask

    task automatic model_cand(input logic [79:0] c, input logic [15:0] mv, input bit last);
        logic [15:0] ci;
        bit          upd;
        exp_t        e;
        if (!m_search) return;
        for (int i = 0; i < 5; i++) begin
            ci  = c[16*i +: 16];
            upd = (ci < m_cost[i]);
`ifdef IME_TIE_SMALL_MV_EN
            if (ci == m_cost[i] && mag(mv) < mag(m_mv[i])) upd = 1'b1;
`endif
            if (upd) begin
                m_cost[i] = ci;
                m_mv[i]   = mv;
            end
        end
        if (m_cnt != 10'h3FF) m_cnt = m_cnt + 10'd1;
        if (last) begin
            for (int i = 0; i < 5; i++) begin
                e.cost[16*i +: 16] = m_cost[i];
                e.mv[16*i +: 16]   = m_mv[i];
            end
            e.cnt = m_cnt;
            sb.push_back(e);
            m_search = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_cost"}, {best_cost16x16_o, best_cost16x8_o, best_cost8x16_o} >> (16*i) & 80'hFFFF, m_cost[i]);
            chk({tag, "_mv"}, {best_mv16x16_o, best_mv16x8_o, best_mv8x16_o} >> (16*i) & 80'hFFFF, m_mv[i]);
        end
        chk({tag, "_cnt"}, cand_cnt_o, m_cnt);
    endtask

    // Called at a falling edge; returns one falling edge later.
    task automatic do_start();
        start_i = 1'b1;
        model_reset(1'b1);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic cand(input logic [79:0] c, input logic [15:0] mv, input bit last);
        cost8x16_i  = c[31:0];
        cost16x8_i  = c[63:32];
        cost16x16_i = c[79:64];
        mv_i        = mv;
        last_i      = last;
        cost_v_i    = 1'b1;
        model_cand(c, mv, last);
        @(negedge clk);
    endtask

    task automatic idle_in();
        cost_v_i = 1'b0;
        last_i   = 1'b0;
    endtask

    // Expects done_o right now (one cycle after the accepting edge).
    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, "_done"}, done_o, 1'b1);
        chk({tag, "_sbsize"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sbcost"}, {best_cost16x16_o, best_cost16x8_o, best_cost8x16_o}, e.cost);
            chk({tag, "_sbmv"}, {best_mv16x16_o, best_mv16x8_o, best_mv8x16_o}, e.mv);
            chk({tag, "_sbcnt"}, cand_cnt_o, e.cnt);
            $display("txn %s: done cost16x16=%0d mv16x16=%04h cnt=%0d", tag, best_cost16x16_o, best_mv16x16_o, cand_cnt_o);
        end
        idle_in();
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_o, 1'b0);
        chk({tag, "_busy_after"}, busy_o, 1'b0);
    endtask

    logic [79:0] gc [5];
    logic [15:0] gm [5];

    initial begin
        model_reset(1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs("reset");
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // Tie handling on 16x16: 500, 300, 300
        do_start();
        chk("t1_busy", busy_o, 1'b1);
        cand(pk(1000, 1000, 1000, 1000, 500), {8'd1, 8'd1}, 1'b0);
        cand(pk(1000, 1000, 1000, 1000, 300), {8'd2, 8'hFD}, 1'b0);
        cand(pk(1000, 1000, 1000, 1000, 300), {8'd0, 8'd1}, 1'b1);
        check_done("tie");
        chk("tie_cost16x16", best_cost16x16_o, 16'd300);
`ifdef IME_TIE_SMALL_MV_EN
        chk("tie_mv16x16", best_mv16x16_o, 16'h0001);
`else
        chk("tie_mv16x16", best_mv16x16_o, 16'h02FD);
`endif
        chk("tie_cnt", cand_cnt_o, 10'd3);

        // Per-partition independence, A=(4,0) B=(-4,0)
        do_start();
        cand(pk(10, 90, 70, 5, 40), 16'h0400, 1'b0);
        cand(pk(20, 80, 30, 50, 40), 16'hFC00, 1'b1);
        check_done("indep");
        chk("indep_c8x16", best_cost8x16_o, {16'd80, 16'd10});
        chk("indep_m8x16", best_mv8x16_o, {16'hFC00, 16'h0400});
        chk("indep_c16x8", best_cost16x8_o, {16'd5, 16'd30});
        chk("indep_m16x8", best_mv16x8_o, {16'h0400, 16'hFC00});
        chk("indep_m16x16", best_mv16x16_o, 16'h0400);

        // Abort with a simultaneous candidate of cost 5
        do_start();
        cand(pk(100, 100, 100, 100, 100), 16'h0102, 1'b0);
        cand(pk(50, 50, 50, 50, 50), 16'h0304, 1'b0);
        start_i = 1'b1;
        cost8x16_i = {16'd5, 16'd5}; cost16x8_i = {16'd5, 16'd5}; cost16x16_i = 16'd5;
        mv_i = 16'h0707; cost_v_i = 1'b1; last_i = 1'b0;
        model_reset(1'b1);
        chk("abort_nodone0", done_o, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        idle_in();
        check_outputs("abort");
        chk("abort_cost16x16", best_cost16x16_o, 16'hFFFF);
        chk("abort_cnt", cand_cnt_o, 10'd0);
        chk("abort_busy", busy_o, 1'b1);
        chk("abort_nodone1", done_o, 1'b0);
        cand(pk(7, 7, 7, 7, 7), 16'h0102, 1'b1);
        check_done("abort_fin");

        // Valid while IDLE is ignored
        cand(pk(1, 1, 1, 1, 1), 16'h0505, 1'b0);
        cand(pk(1, 1, 1, 1, 1), 16'h0505, 1'b1);
        idle_in();
        check_outputs("idle_ign");
        chk("idle_ign_busy", busy_o, 1'b0);
        chk("idle_ign_done", done_o, 1'b0);

        // Single candidate: cost 0 wins, all-ones 16x16 never updates
        do_start();
        cand(pk(0, 0, 0, 0, 16'hFFFF), 16'h8080, 1'b1);
        check_done("single");
        chk("single_c8x16", best_cost8x16_o, 32'd0);
        chk("single_m8x16", best_mv8x16_o, 32'h80808080);
        chk("single_c16x16", best_cost16x16_o, 16'hFFFF);
        chk("single_m16x16", best_mv16x16_o, 16'h0000);

        // Gapped valid (every 3rd cycle) then the same set back-to-back
        for (int k = 0; k < 5; k++) begin
            gc[k] = pk(16'($urandom_range(0, 3) * 100), 16'($urandom_range(0, 3) * 100),
                       16'($urandom_range(0, 3) * 100), 16'($urandom_range(0, 3) * 100),
                       16'($urandom_range(0, 3) * 100));
            gm[k] = 16'($urandom);
        end
        do_start();
        for (int k = 0; k < 5; k++) begin
            cand(gc[k], gm[k], k == 4);
            if (k < 4) begin
                idle_in();
                @(negedge clk);
                chk("gap_busy", busy_o, 1'b1);
                @(negedge clk);
                chk("gap_busy", busy_o, 1'b1);
            end
        end
        check_done("gap");
        do_start();
        for (int k = 0; k < 5; k++) cand(gc[k], gm[k], k == 4);
        check_done("b2b");

        // Counter saturation
        do_start();
        for (int k = 0; k < 1030; k++) begin
            cand(pk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)),
                 16'($urandom), k == 1029);
        end
        check_done("sat");
        chk("sat_cnt", cand_cnt_o, 10'h3FF);

        // Asynchronous reset mid-search
        do_start();
        cand(pk(3, 3, 3, 3, 3), 16'h0101, 1'b0);
        cand(pk(2, 2, 2, 2, 2), 16'h0202, 1'b0);
        idle_in();
        #2 rstn = 1'b0;
        model_reset(1'b0);
        #1;
        check_outputs("arst");
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_done", done_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_nodone", done_o, 1'b0);
            chk("arst_idle", busy_o, 1'b0);
        end
        check_outputs("arst_hold");

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
